dlfloat16_sqrt_sched: RTL

Shares one combinational DLFloat16 square-root core among NREQ requesters.
- Arbitrates between requesters round-robin.
- Registers the winning operand and drives it into the core.
- Waits a programmable settle time, then captures the 20-bit result and 5-bit exception flags.
- Returns the result with a requester tag over a valid/ready port.

The block sits between the FPU issue logic and the sqrt core, and keeps sticky exception flags for the FPU status register.

---
 rtl/dlfloat16_sqrt_sched.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/dlfloat16_sqrt_sched.sv
// dlfloat16_sqrt_sched: shares one combinational DLFloat16 square-root core
// among NREQ requesters.
//   - Round-robin arbitration picks one requester while idle.
//   - The winning operand is registered onto core_in_o and held for CORE_LAT cycles.
//   - Result and flags are then captured and returned with the requester tag.
//   - Sticky flags accumulate for the FPU status register.
// Ports:
//   clk_i, rst_i              clock (rising edge), async active-high reset
//   req_valid_i/req_data_i    per-requester operand valid / operands (16 bits each)
//   req_ready_o               one-hot accept (combinational, idle only)
//   core_in_o                 registered operand to the sqrt core
//   core_out_i/core_flags_i   core result / {invalid, inexact, overflow, underflow, div_by_zero}
//   res_valid_o/res_ready_i   result handshake
//   res_data_o/res_flags_o    captured result / captured flags
//   res_tag_o                 owning requester index
//   busy_o                    scheduler not idle
//   sticky_flags_o            OR-accumulated flags
//   clear_flags_i             synchronous clear of the sticky flags
module dlfloat16_sqrt_sched #(
    parameter int unsigned NREQ     = 4,
    parameter int unsigned TAGW     = 2,
    parameter int unsigned CORE_LAT = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NREQ-1:0]      req_valid_i,
    input  logic [16*NREQ-1:0]   req_data_i,
    output logic [NREQ-1:0]      req_ready_o,
    output logic [15:0]          core_in_o,
    input  logic [19:0]          core_out_i,
    input  logic [4:0]           core_flags_i,
    output logic                 res_valid_o,
    output logic [19:0]          res_data_o,
    output logic [4:0]           res_flags_o,
    output logic [TAGW-1:0]      res_tag_o,
    input  logic                 res_ready_i,
    output logic                 busy_o,
    output logic [4:0]           sticky_flags_o,
    input  logic                 clear_flags_i
);

    localparam int unsigned DW = 16;
    localparam int unsigned RW = 20;
    localparam int unsigned FW = 5;
    localparam int unsigned CW = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [TAGW-1:0] rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]   core_in_q, core_in_d;
    logic            res_valid_q, res_valid_d;
    logic [RW-1:0]   res_data_q, res_data_d;
    logic [FW-1:0]   res_flags_q, res_flags_d;
    logic [TAGW-1:0] res_tag_q, res_tag_d;
    logic [FW-1:0]   sticky_q, sticky_d;

    logic            grant_vld_c;
    logic [TAGW-1:0] grant_idx_c;
    logic [TAGW-1:0] scan_idx_c;
    logic [DW-1:0]   grant_op_c;

    // (base + off) mod NREQ, valid for off < NREQ and any NREQ in 2..8
    function automatic logic [TAGW-1:0] wrap_idx(input logic [TAGW-1:0] base,
                                                 input int unsigned     off);
        int unsigned s;
        s = 32'(base) + off;
        if (s >= NREQ) begin
            s = s - NREQ;
        end
        return TAGW'(s);
    endfunction

    // Round-robin scan starting at rr_ptr_q; first valid requester wins
    always_comb begin
        grant_vld_c = 1'b0;
        grant_idx_c = '0;
        scan_idx_c  = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            scan_idx_c = wrap_idx(rr_ptr_q, k);
            if (!grant_vld_c && req_valid_i[scan_idx_c]) begin
                grant_vld_c = 1'b1;
                grant_idx_c = scan_idx_c;
            end
        end
        grant_op_c = req_data_i[32'(grant_idx_c)*DW +: DW];
    end

    // Accept is only offered while idle; forced low during reset
    always_comb begin
        req_ready_o = '0;
        if (!rst_i && (state_q == ST_IDLE) && grant_vld_c) begin
            req_ready_o = NREQ'(1) << grant_idx_c;
        end
    end

    // Next-state and datapath updates
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        cnt_d       = cnt_q;
        core_in_d   = core_in_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_flags_d = res_flags_q;
        res_tag_d   = res_tag_q;
        sticky_d    = clear_flags_i ? '0 : sticky_q;

        case (state_q)
            ST_IDLE: begin
                if (grant_vld_c) begin
                    core_in_d = grant_op_c;
                    res_tag_d = grant_idx_c;
                    rr_ptr_d  = wrap_idx(grant_idx_c, 1);
                    cnt_d     = CW'(CORE_LAT - 1);
                    state_d   = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    res_data_d  = core_out_i;
                    res_flags_d = core_flags_i;
                    res_valid_d = 1'b1;
                    // new flags survive a simultaneous clear
                    sticky_d    = sticky_d | core_flags_i;
                    state_d     = ST_DONE;
                end
            end
            ST_DONE: begin
                if (res_valid_q && res_ready_i) begin
                    res_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            cnt_q       <= '0;
            core_in_q   <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_flags_q <= '0;
            res_tag_q   <= '0;
            sticky_q    <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            cnt_q       <= cnt_d;
            core_in_q   <= core_in_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_flags_q <= res_flags_d;
            res_tag_q   <= res_tag_d;
            sticky_q    <= sticky_d;
        end
    end

    assign core_in_o      = core_in_q;
    assign res_valid_o    = res_valid_q;
    assign res_data_o     = res_data_q;
    assign res_flags_o    = res_flags_q;
    assign res_tag_o      = res_tag_q;
    assign sticky_flags_o = sticky_q;
    assign busy_o         = (state_q != ST_IDLE);

endmodule
